// File: rtl/command_sequencer_mc.sv
// Command sequencer for the acoustics UART control path: decodes opcodes, issues
// load strobes, reports the peak value and runs per-channel trigger detection with a timeout.
module command_sequencer_mc #(
    parameter int NUM_CH         = 4,
    parameter int OFFSET_W       = 2,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int OP_W           = 4
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic                rx_ready,
    input  logic [OP_W-1:0]     rx_cmd,
    input  logic                fft_data_ready,
    input  logic                trigger,
    input  logic [7:0]          max_value,
    input  logic                tx_busy,
    input  logic                tx_done,
    output logic [OFFSET_W-1:0] ram_read_offset,
    output logic                frequency_load,
    output logic                threshold_load,
    output logic [7:0]          tx_word,
    output logic                tx_start,
    output logic                detect_active,
    output logic [OFFSET_W-1:0] hit_channel
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam int CNT_W = OFFSET_W + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CH);
    localparam logic [OP_W-1:0]  OP_FREQ   = OP_W'(4'hF);
    localparam logic [OP_W-1:0]  OP_THR    = OP_W'(4'h7);
    localparam logic [OP_W-1:0]  OP_MAX    = OP_W'(4'h4);
    localparam logic [OP_W-1:0]  OP_SINGLE = OP_W'(4'hD);
    localparam logic [OP_W-1:0]  OP_CONT   = OP_W'(4'hE);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECODE   = 3'd1,
        ST_WAIT_FFT = 3'd2,
        ST_SCAN     = 3'd3,
        ST_TX_START = 3'd4,
        ST_TX_WAIT  = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [OP_W-1:0]     op_r, op_s;
    logic                cont_r, cont_s;
    logic [TMR_W-1:0]    timer_r, timer_s, timer_inc_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s, cnt_inc_s;
    logic [OFFSET_W-1:0] offset_r, offset_s;
    logic [OFFSET_W-1:0] hit_r, hit_s, ch_s;
    logic                freq_load_r, freq_load_s;
    logic                thr_load_r, thr_load_s;
    logic [7:0]          tx_word_r, tx_word_s;
    logic                tx_start_r, tx_start_s;
    logic                active_r, active_s;

    // Next-state and next-output computation for every register.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        cont_s      = cont_r;
        timer_s     = timer_r;
        cnt_s       = cnt_r;
        offset_s    = {OFFSET_W{1'b0}};
        hit_s       = hit_r;
        freq_load_s = 1'b0;
        thr_load_s  = 1'b0;
        tx_word_s   = tx_word_r;
        tx_start_s  = 1'b0;
        timer_inc_s = (timer_r == {TMR_W{1'b1}}) ? timer_r : timer_r + TMR_W'(1);
        cnt_inc_s   = cnt_r + CNT_W'(1);
        // The trigger seen now answers the offset issued on the previous cycle.
        ch_s        = OFFSET_W'(cnt_r - CNT_W'(1));
        case (state_r)
            ST_IDLE: begin
                if (rx_ready) begin
                    op_s    = rx_cmd;
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                case (op_r)
                    OP_FREQ: begin
                        freq_load_s = 1'b1;
                        state_s     = ST_IDLE;
                    end
                    OP_THR: begin
                        thr_load_s = 1'b1;
                        state_s    = ST_IDLE;
                    end
                    OP_MAX: begin
                        tx_word_s = max_value;
                        state_s   = ST_TX_START;
                    end
                    OP_SINGLE, OP_CONT: begin
                        cont_s  = (op_r == OP_CONT);
                        timer_s = {TMR_W{1'b0}};
                        state_s = ST_WAIT_FFT;
                    end
                    default: state_s = ST_IDLE;
                endcase
            end
            ST_WAIT_FFT: begin
                timer_s = timer_inc_s;
                if (rx_ready) begin
                    op_s    = rx_cmd;
                    state_s = ST_DECODE;
                end else if (timer_r == TMR_LAST) begin
                    tx_word_s = 8'h00;
                    state_s   = ST_TX_START;
                end else if (fft_data_ready) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_WAIT_FFT;
                end
            end
            ST_SCAN: begin
                timer_s = timer_inc_s;
                if (rx_ready) begin
                    op_s    = rx_cmd;
                    state_s = ST_DECODE;
                end else if ((cnt_r != {CNT_W{1'b0}}) && trigger) begin
                    hit_s     = ch_s;
                    tx_word_s = {1'b1, 7'(ch_s)};
                    state_s   = ST_TX_START;
                end else if (timer_r == TMR_LAST) begin
                    tx_word_s = 8'h00;
                    state_s   = ST_TX_START;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_WAIT_FFT;
                end else begin
                    cnt_s    = cnt_inc_s;
                    offset_s = (cnt_inc_s < CNT_LAST) ? OFFSET_W'(cnt_inc_s) : {OFFSET_W{1'b0}};
                    state_s  = ST_SCAN;
                end
            end
            ST_TX_START: begin
                if (!tx_busy) begin
                    tx_start_s = 1'b1;
                    state_s    = ST_TX_WAIT;
                end else begin
                    state_s = ST_TX_START;
                end
            end
            ST_TX_WAIT: begin
                if (tx_done && cont_r) begin
                    timer_s = {TMR_W{1'b0}};
                    state_s = ST_WAIT_FFT;
                end else if (tx_done) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_TX_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        active_s = (state_s == ST_WAIT_FFT) || (state_s == ST_SCAN);
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_r     <= ST_IDLE;
            op_r        <= {OP_W{1'b0}};
            cont_r      <= 1'b0;
            timer_r     <= {TMR_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            offset_r    <= {OFFSET_W{1'b0}};
            hit_r       <= {OFFSET_W{1'b0}};
            freq_load_r <= 1'b0;
            thr_load_r  <= 1'b0;
            tx_word_r   <= 8'h00;
            tx_start_r  <= 1'b0;
            active_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            cont_r      <= cont_s;
            timer_r     <= timer_s;
            cnt_r       <= cnt_s;
            offset_r    <= offset_s;
            hit_r       <= hit_s;
            freq_load_r <= freq_load_s;
            thr_load_r  <= thr_load_s;
            tx_word_r   <= tx_word_s;
            tx_start_r  <= tx_start_s;
            active_r    <= active_s;
        end
    end

    assign ram_read_offset = offset_r;
    assign frequency_load  = freq_load_r;
    assign threshold_load  = thr_load_r;
    assign tx_word         = tx_word_r;
    assign tx_start        = tx_start_r;
    assign detect_active   = active_r;
    assign hit_channel     = hit_r;
endmodule
